// File: rtl/inverse_zigzag_buffer_pkg.sv
// inverse_zigzag_buffer_pkg: block size, zigzag table and default coefficient width shared with the encoder ROM.
package inverse_zigzag_buffer_pkg;
  localparam int BLK = 16;
  localparam int COEF_W_DEF = 16;
  // Entry k (scan index) sits at bits [4k +: 4] and holds the raster position.
  localparam logic [63:0] ZZ_TABLE = {4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
                                      4'd6, 4'd3, 4'd2, 4'd5, 4'd8, 4'd4, 4'd1, 4'd0};
  function automatic logic [3:0] zz_raster(input logic [3:0] k);
    return ZZ_TABLE[{k, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/inverse_zigzag_buffer_lut.sv
// zigzag_scan_lut: combinational scan-index to raster-position map for a 4x4 block.
module zigzag_scan_lut
  import inverse_zigzag_buffer_pkg::*;
(
  input  logic [3:0] scan_idx,
  output logic [3:0] raster_pos
);
  assign raster_pos = zz_raster(scan_idx);
endmodule

// File: rtl/inverse_zigzag_buffer.sv
// inverse_zigzag_buffer: ping-pong buffer reordering 4x4 scan-order coefficients into raster-order blocks.
module inverse_zigzag_buffer
  import inverse_zigzag_buffer_pkg::*;
#(
  parameter int COEF_W  = COEF_W_DEF,
  parameter int REVERSE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COEF_W-1:0]     in_coef,
  input  logic                  in_valid,
  input  logic                  in_first,
  output logic                  in_ready,
  output logic [BLK*COEF_W-1:0] out_block,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_sync
);
  logic [3:0] cnt_q, cnt_d, step, scan_idx, raster_pos;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, err_sync_q, err_sync_d;
  logic [1:0] full_q, full_d;
  logic xfer, drain, done;
  logic [COEF_W-1:0] mem_q [2][BLK];
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign err_sync  = err_sync_q;
  assign xfer      = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  // A framing marker restarts the block at step 0 regardless of the counter.
  assign step      = in_first ? 4'd0 : cnt_q;
  assign scan_idx  = (REVERSE != 0) ? 4'd15 - step : step;
  assign done      = xfer && step == 4'd15;
  zigzag_scan_lut u_lut (.scan_idx(scan_idx), .raster_pos(raster_pos));
  always_comb begin
    cnt_d      = xfer ? step + 4'd1 : cnt_q;
    wr_bank_d  = wr_bank_q ^ done;
    rd_bank_d  = rd_bank_q ^ drain;
    err_sync_d = xfer && (in_first ? cnt_q != 4'd0 : cnt_q == 4'd0);
    full_d     = full_q;
    if (drain) full_d[rd_bank_q] = 1'b0;
    if (done) full_d[wr_bank_q] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 4'd0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      err_sync_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      err_sync_q <= err_sync_d;
    end
  end
  always_ff @(posedge clk) begin
    if (xfer) mem_q[wr_bank_q][raster_pos] <= in_coef;
  end
  always_comb begin
    for (int r = 0; r < BLK; r++) out_block[r*COEF_W +: COEF_W] = mem_q[rd_bank_q][r];
  end
endmodule

// File: doc/inverse_zigzag_buffer.md
INVERSE_ZIGZAG_BUFFER -- requirements
Module: inverse_zigzag_buffer

Interface
REQ-001 SHALL have parameter COEF_W, default 16, the signed coefficient width in bits.
REQ-002 SHALL have parameter REVERSE, default 1; 1 = input arrives in reverse scan order (scan index 15..0), 0 = forward scan order (0..15).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_coef, input, COEF_W bits, signed coefficient in scan order.
REQ-006 SHALL have port in_valid, input, 1 bit, in_coef is valid.
REQ-007 SHALL have port in_first, input, 1 bit, marks the first coefficient of a 4x4 block; qualified by in_valid.
REQ-008 SHALL have port in_ready, output, 1 bit, the buffer accepts in_coef this cycle.
REQ-009 SHALL have port out_block, output, 16*COEF_W bits, raster-order block; raster position r occupies bits [r*COEF_W +: COEF_W].
REQ-010 SHALL have port out_valid, output, 1 bit, out_block holds a complete block.
REQ-011 SHALL have port out_ready, input, 1 bit, the consumer takes out_block.
REQ-012 SHALL have port err_sync, output, 1 bit, one-cycle pulse on a block-framing error.

Function
REQ-013 SHALL map scan index k to raster position ZZ[k] = {0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15}.
REQ-014 SHALL keep a 4-bit write counter cnt; the scan index is 15-cnt when REVERSE=1, else cnt.
REQ-015 SHALL transfer a coefficient only when in_valid and in_ready are both high, writing it to raster position ZZ[scan index] of the current write bank and incrementing cnt.
REQ-016 SHALL hold two ping-pong banks of 16 coefficients, each with a full flag, plus a write-bank pointer wr_bank and a read-bank pointer rd_bank.
REQ-017 SHALL drive in_ready = !full[wr_bank].
REQ-018 SHALL, on the 16th transfer (cnt==15), set full[wr_bank], toggle wr_bank and wrap cnt to 0 in the same edge.
REQ-019 SHALL drive out_valid = full[rd_bank] and out_block = bank[rd_bank]; out_valid rises the cycle after the 16th transfer (latency 1).
REQ-020 SHALL, on out_valid && out_ready, clear full[rd_bank] and toggle rd_bank.
REQ-021 SHALL hold out_block stable while out_valid is high and out_ready is low.
REQ-022 SHALL process block completion and drain on different banks in the same cycle independently, so both take effect.
REQ-023 SHALL sustain one coefficient per clock when the consumer drains each block within 16 cycles.
REQ-024 SHALL, on a transfer with in_first=1 while cnt!=0, discard the partial block, write this coefficient as scan step 0 of the same bank, set cnt to 1 and pulse err_sync for one cycle.
REQ-025 SHALL, on a transfer with in_first=0 while cnt==0, accept the coefficient as step 0 and pulse err_sync.
REQ-026 SHALL leave raster positions not written since the last bank drain undefined; only full blocks are presented.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear cnt, wr_bank, rd_bank, both full flags and err_sync, giving in_ready=1 and out_valid=0 during and after reset.
REQ-028 SHALL not reset the coefficient storage; out_block is don't-care while out_valid=0.
REQ-029 SHALL discard any partial or buffered block when reset asserts mid-operation.

Structure
REQ-030 SHALL place the block size (16), the ZZ table and the default COEF_W in a shared package used with the encoder's zigzag ROM.
REQ-031 SHALL use one combinational sub-module, zigzag_scan_lut, that maps scan index to raster position.

Verification
REQ-032 SHALL cover REVERSE=1 with inputs 15,14,...,0 (value = scan index) and out_ready=1: out_valid on the cycle after the 16th transfer, raster r holds the k where ZZ[k]=r (r2=5, r3=6, r4=2, r12=9).
REQ-033 SHALL cover REVERSE=0 with inputs 0..15: raster order {0,1,5,6,2,4,7,12,3,8,11,13,9,10,14,15}.
REQ-034 SHALL cover out_ready=0 with 40 coefficients streamed: in_ready drops after 32 transfers, and after draining, the blocks come out in order A then B.
REQ-035 SHALL cover in_first asserted at cnt=7: err_sync pulses once, and the next 16 transfers form one correct block.
REQ-036 SHALL cover rst_n pulsed low at cnt=9 with one full bank: out_valid=0, in_ready=1, cnt=0 immediately, and the next block decodes correctly.
REQ-037 SHALL cover back-to-back blocks with out_ready=1: in_ready stays high continuously for 64 transfers, giving 4 blocks.
